// File: rtl/gsim_pkg.sv
// Shared types and constants for the Gauss-Seidel job arbiter.
// Describes the solver core's fixed geometry and timing.
package gsim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DRAIN
    } gsim_state_t;

    localparam int GSIM_VEC_LEN     = 16;
    localparam int GSIM_B_W         = 16;
    localparam int GSIM_X_W         = 32;
    localparam int GSIM_CALC_CYCLES = 1232;

endpackage

// File: rtl/gsim_job_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or above
// ptr, wrapping around, for N_REQ requesters.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any_req
);

    int s;

    // Scan from the farthest slot back to ptr so the nearest hit wins.
    always_comb begin
        grant = '0;
        s     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= N_REQ) s = s - N_REQ;
            if (req[s]) grant = ID_W'(s);
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/gsim_job_arbiter.sv
// Shares one Gauss-Seidel solver core among N_REQ requesters: job-level
// round-robin, streams 16 b words in, forwards 16 tagged x words out.
module gsim_job_arbiter
    import gsim_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int VEC_LEN  = GSIM_VEC_LEN,
    parameter int B_W      = GSIM_B_W,
    parameter int X_W      = GSIM_X_W,
    parameter int WAIT_MAX = 2047,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*B_W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               core_in_en,
    output logic [B_W-1:0]     core_b_in,
    input  logic               core_out_valid,
    input  logic [X_W-1:0]     core_x_out,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [3:0]         rsp_idx,
    output logic [X_W-1:0]     rsp_data,
    output logic               rsp_last,
    output logic               busy,
    output logic [ID_W-1:0]    owner,
    output logic [15:0]        jobs_done,
    output logic               err_timeout,
    output logic               err_unexpected
);

    localparam int WD_W = $clog2(WAIT_MAX + 1);
    localparam logic [3:0]      LAST_IDX = 4'(VEC_LEN - 1);
    localparam logic [ID_W-1:0] LAST_REQ = ID_W'(N_REQ - 1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(WAIT_MAX);
    localparam logic [WD_W-1:0] WD_PRE   = WD_W'(WAIT_MAX - 1);

    gsim_state_t     state, state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic            any_req;
    logic [3:0]      wcnt;
    logic [3:0]      beat;
    logic [WD_W-1:0] wdog;
    logic [B_W-1:0]  owner_data;
    logic            xfer;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    assign owner_data = req_data[int'(owner)*B_W +: B_W];
    assign xfer       = (state == LOAD) && req_valid[owner];
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and the owner-only ready decode.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        unique case (state)
            IDLE:  if (any_req) state_next = LOAD;
            LOAD: begin
                req_ready[owner] = 1'b1;
                if (xfer && wcnt == LAST_IDX) state_next = WAIT;
            end
            WAIT:  if (core_out_valid) state_next = DRAIN;
            DRAIN: if (core_out_valid && beat == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant, load, watchdog, drain and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr         <= '0;
            owner          <= '0;
            wcnt           <= '0;
            beat           <= '0;
            wdog           <= '0;
            core_in_en     <= 1'b0;
            core_b_in      <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_idx        <= '0;
            rsp_data       <= '0;
            rsp_last       <= 1'b0;
            jobs_done      <= '0;
            err_timeout    <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            core_in_en <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_last   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (core_out_valid) err_unexpected <= 1'b1;
                    if (any_req) begin
                        owner  <= grant;
                        rr_ptr <= (grant == LAST_REQ) ? '0 : grant + 1'b1;
                        wcnt   <= '0;
                        beat   <= '0;
                    end
                end
                LOAD: begin
                    if (core_out_valid) err_unexpected <= 1'b1;
                    if (xfer) begin
                        core_in_en <= 1'b1;
                        core_b_in  <= owner_data;
                        wcnt       <= wcnt + 4'd1;
                        if (wcnt == LAST_IDX) wdog <= '0;
                    end
                end
                WAIT: begin
                    if (core_out_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= core_x_out;
                        rsp_idx   <= beat;
                        rsp_id    <= owner;
                        beat      <= beat + 4'd1;
                    end else begin
                        if (wdog != WD_MAX) wdog <= wdog + 1'b1;
                        if (wdog == WD_PRE) err_timeout <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (core_out_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= core_x_out;
                        rsp_idx   <= beat;
                        rsp_id    <= owner;
                        rsp_last  <= (beat == LAST_IDX);
                        beat      <= beat + 4'd1;
                        if (beat == LAST_IDX && jobs_done != 16'hFFFF)
                            jobs_done <= jobs_done + 16'd1;
                    end else begin
                        err_unexpected <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_job_arbiter.sv
// Directed bench for gsim_job_arbiter: behavioural requesters and core,
// a table of single jobs, then arbitration and error sequences.
module tb_gsim_job_arbiter;

    localparam int N        = 4;
    localparam int ID_W     = 2;
    localparam int B_W      = 16;
    localparam int X_W      = 32;
    localparam int WAIT_MAX = 2047;
    localparam int CALC     = 1232;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*B_W-1:0]  req_data;
    logic [N-1:0]      req_ready;
    logic              core_in_en;
    logic [B_W-1:0]    core_b_in;
    logic              core_out_valid;
    logic [X_W-1:0]    core_x_out;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [3:0]        rsp_idx;
    logic [X_W-1:0]    rsp_data;
    logic              rsp_last;
    logic              busy;
    logic [ID_W-1:0]   owner;
    logic [15:0]       jobs_done;
    logic              err_timeout;
    logic              err_unexpected;

    gsim_job_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .core_in_en     (core_in_en),
        .core_b_in      (core_b_in),
        .core_out_valid (core_out_valid),
        .core_x_out     (core_x_out),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_idx        (rsp_idx),
        .rsp_data       (rsp_data),
        .rsp_last       (rsp_last),
        .busy           (busy),
        .owner          (owner),
        .jobs_done      (jobs_done),
        .err_timeout    (err_timeout),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    typedef struct { int own; logic [15:0] d; int cyc; } in_rec_t;
    typedef struct { int id; int idx; logic [31:0] d; logic last; } rsp_rec_t;
    typedef struct { int own; int idle; } gnt_rec_t;
    typedef struct {
        int          req;
        int          st_at;
        int          st_len;
        logic [31:0] x0;
        logic [15:0] exp_done;
    } job_vec_t;

    in_rec_t  in_log[$];
    rsp_rec_t rsp_log[$];
    gnt_rec_t gnt_log[$];

    // Written by the main sequence only.
    int          asked[N];
    int          stall_at[N];
    int          stall_len[N];
    logic [15:0] base[N];
    bit          core_en;
    logic [31:0] core_xbase;
    int          inject_req;

    // Written by the engine only.
    int served[N];
    int cnt[N];
    int st_cnt[N];
    int cyc, in_cnt, cd, ek, inject_done, viol, idle_run, to_cyc;
    bit pending, busy_d;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Requesters, core model and monitors, all stepped on the falling edge.
    initial begin
        cyc = 0; in_cnt = 0; cd = 0; ek = -1; inject_done = 0;
        viol = 0; idle_run = 0; to_cyc = -1; pending = 0; busy_d = 0;
        for (int i = 0; i < N; i++) begin
            served[i] = 0; cnt[i] = 0; st_cnt[i] = 0;
        end
        req_valid = '0; req_data = '0;
        core_out_valid = 1'b0; core_x_out = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                for (int i = 0; i < N; i++) begin
                    served[i] = asked[i]; cnt[i] = 0; st_cnt[i] = 0;
                end
                in_cnt = 0; pending = 0; ek = -1; inject_done = inject_req;
                busy_d = 0; idle_run = 0; to_cyc = -1;
                req_valid = '0; core_out_valid = 1'b0;
            end else begin
                if (core_in_en)
                    in_log.push_back('{int'(owner), core_b_in, cyc});
                if (rsp_valid)
                    rsp_log.push_back('{int'(rsp_id), int'(rsp_idx),
                                        rsp_data, rsp_last});
                if (busy && !busy_d) gnt_log.push_back('{int'(owner), idle_run});
                idle_run = busy ? 0 : idle_run + 1;
                busy_d   = busy;
                if (err_timeout && to_cyc < 0) to_cyc = cyc;
                if (busy && (req_ready & ~(4'b0001 << owner)) != 0) viol++;
                if (!busy && req_ready != 0) viol++;

                for (int i = 0; i < N; i++) begin
                    bit v;
                    if (core_in_en && int'(owner) == i) begin
                        cnt[i]++;
                        if (cnt[i] == 16) begin
                            cnt[i] = 0; st_cnt[i] = 0; served[i]++;
                        end
                    end
                    v = (asked[i] > served[i]);
                    if (v && cnt[i] == stall_at[i] && st_cnt[i] < stall_len[i]) begin
                        v = 0;
                        st_cnt[i]++;
                    end
                    req_valid[i] = v;
                    req_data[i*B_W +: B_W] = base[i] + 16'(cnt[i]);
                end

                core_out_valid = 1'b0;
                if (inject_req != inject_done) begin
                    core_out_valid = 1'b1;
                    core_x_out     = 32'hDEAD_BEEF;
                    inject_done    = inject_req;
                end else if (pending && core_en) begin
                    if (ek < 0) begin
                        cd--;
                        if (cd == 0) ek = 0;
                    end
                    if (ek >= 0) begin
                        core_out_valid = 1'b1;
                        core_x_out     = core_xbase + 32'(ek);
                        ek++;
                        if (ek == 16) begin ek = -1; pending = 0; end
                    end
                end
                if (core_in_en) begin
                    in_cnt++;
                    if (in_cnt == 16) begin in_cnt = 0; pending = 1; cd = CALC; end
                end
            end
        end
    end

    task automatic check_idle_outputs(input string nm);
        check({nm, "_req_ready"}, req_ready, 0);
        check({nm, "_core_in_en"}, core_in_en, 0);
        check({nm, "_core_b_in"}, core_b_in, 0);
        check({nm, "_rsp_valid"}, rsp_valid, 0);
        check({nm, "_rsp_id"}, rsp_id, 0);
        check({nm, "_rsp_idx"}, rsp_idx, 0);
        check({nm, "_rsp_data"}, rsp_data, 0);
        check({nm, "_rsp_last"}, rsp_last, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_owner"}, owner, 0);
        check({nm, "_jobs_done"}, jobs_done, 0);
        check({nm, "_err_timeout"}, err_timeout, 0);
        check({nm, "_err_unexpected"}, err_unexpected, 0);
    endtask

    task automatic check_job(input string nm, input int req,
                             input logic [31:0] x0, input int io, input int ro);
        check({nm, "_in_count"}, (in_log.size() >= io + 16), 1);
        check({nm, "_rsp_count"}, (rsp_log.size() >= ro + 16), 1);
        for (int k = 0; k < 16; k++) begin
            if (io + k < in_log.size()) begin
                check($sformatf("%s_in%0d_data", nm, k), in_log[io+k].d,
                      base[req] + 16'(k));
                check($sformatf("%s_in%0d_own", nm, k), in_log[io+k].own, req);
            end
            if (ro + k < rsp_log.size()) begin
                check($sformatf("%s_rsp%0d_id", nm, k), rsp_log[ro+k].id, req);
                check($sformatf("%s_rsp%0d_idx", nm, k), rsp_log[ro+k].idx, k);
                check($sformatf("%s_rsp%0d_data", nm, k), rsp_log[ro+k].d,
                      x0 + 32'(k));
                check($sformatf("%s_rsp%0d_last", nm, k), rsp_log[ro+k].last,
                      (k == 15));
            end
        end
    endtask

    task automatic wait_jobs(input string nm, input logic [15:0] target);
        int n = 0;
        while (jobs_done != target && n < 6000) begin tick(); n++; end
        check({nm, "_jobs_done"}, jobs_done, target);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    job_vec_t vec[4];

    initial begin
        int io, ro, go, c0, n;
        reset = 1'b1;
        core_en = 1'b1; core_xbase = '0; inject_req = 0;
        for (int i = 0; i < N; i++) begin
            asked[i] = 0; stall_at[i] = -1; stall_len[i] = 0;
            base[i] = 16'(1 + i * 'h1000);
        end
        vec[0] = '{0, -1, 0, 32'h0000_0100, 16'd1};
        vec[1] = '{1,  7, 5, 32'h0000_2000, 16'd2};
        vec[2] = '{2, -1, 0, 32'h3000_0000, 16'd3};
        vec[3] = '{3, 15, 2, 32'hFFFF_FFF0, 16'd4};

        repeat (3) tick();
        check_idle_outputs("rst");
        reset = 1'b0;
        tick();

        // Single jobs, one requester at a time.
        for (int j = 0; j < 4; j++) begin
            string nm;
            nm = $sformatf("job%0d", j);
            io = in_log.size(); ro = rsp_log.size(); go = gnt_log.size();
            viol = 0;
            stall_at[vec[j].req]  = vec[j].st_at;
            stall_len[vec[j].req] = vec[j].st_len;
            core_xbase = vec[j].x0;
            asked[vec[j].req]++;
            wait_jobs(nm, vec[j].exp_done);
            repeat (3) tick();
            check_job(nm, vec[j].req, vec[j].x0, io, ro);
            check({nm, "_in_exact16"}, in_log.size() - io, 16);
            check({nm, "_rsp_exact16"}, rsp_log.size() - ro, 16);
            check({nm, "_grant"}, (gnt_log.size() > go) ? gnt_log[go].own : -1,
                  vec[j].req);
            check({nm, "_ready_excl"}, viol, 0);
            if (vec[j].st_at > 0 && in_log.size() >= io + 16)
                check({nm, "_stall_gap"},
                      in_log[io+vec[j].st_at].cyc - in_log[io+vec[j].st_at-1].cyc,
                      vec[j].st_len + 1);
        end
        for (int i = 0; i < N; i++) stall_len[i] = 0;
        check("table_err_unexpected", err_unexpected, 0);
        check("table_err_timeout", err_timeout, 0);

        // Simultaneous requests from 1 and 3 after reset, 1 re-requests.
        do_reset();
        io = in_log.size(); ro = rsp_log.size(); go = gnt_log.size();
        core_xbase = 32'h0000_5000;
        asked[1]++; asked[3]++;
        n = 0;
        while (!(busy && owner == 2'd3) && n < 4000) begin tick(); n++; end
        check("rr_owner3", owner, 3);
        asked[1]++;
        wait_jobs("rr", 16'd3);
        repeat (3) tick();
        check("rr_grants", gnt_log.size() - go, 3);
        for (int j = 0; j < 3; j++) begin
            int exp_own;
            exp_own = (j == 1) ? 3 : 1;
            if (gnt_log.size() > go + j)
                check($sformatf("rr_order%0d", j), gnt_log[go+j].own, exp_own);
            check_job($sformatf("rr_job%0d", j), exp_own, 32'h0000_5000,
                      io + 16 * j, ro + 16 * j);
        end
        if (gnt_log.size() >= go + 3) begin
            check("rr_gap1", gnt_log[go+1].idle, 1);
            check("rr_gap2", gnt_log[go+2].idle, 1);
        end

        // Spurious core_out_valid while loading.
        io = in_log.size(); ro = rsp_log.size();
        core_xbase = 32'h0000_7000;
        asked[0]++;
        n = 0;
        while (!(busy && owner == 2'd0 && cnt[0] == 3) && n < 4000) begin
            tick(); n++;
        end
        check("unexp_reach_load", cnt[0], 3);
        inject_req++;
        repeat (3) tick();
        check("unexp_flag", err_unexpected, 1);
        check("unexp_no_rsp", rsp_log.size() - ro, 0);
        wait_jobs("unexp", 16'd4);
        repeat (3) tick();
        check_job("unexp", 0, 32'h0000_7000, io, ro);
        check("unexp_rsp_exact16", rsp_log.size() - ro, 16);

        // Core never answers: watchdog.
        io = in_log.size();
        core_en = 1'b0;
        asked[2]++;
        n = 0;
        while (in_log.size() < io + 16 && n < 4000) begin tick(); n++; end
        check("to_loaded", in_log.size() - io, 16);
        c0 = (in_log.size() >= io + 16) ? in_log[io+15].cyc : 0;
        n = 0;
        while (to_cyc < 0 && n < 2600) begin tick(); n++; end
        check("to_delay", to_cyc - c0, WAIT_MAX);
        check("to_flag", err_timeout, 1);
        check("to_busy", busy, 1);
        check("to_jobs", jobs_done, 4);

        // Reset during drain beat 6, then a fresh job.
        do_reset();
        core_en = 1'b1;
        core_xbase = 32'h0000_9000;
        ro = rsp_log.size();
        asked[2]++;
        n = 0;
        while (rsp_log.size() < ro + 6 && n < 4000) begin tick(); n++; end
        check("rd_beats", rsp_log.size() - ro, 6);
        check("rd_in_drain", busy, 1);
        reset = 1'b1;
        #1;
        check_idle_outputs("rd");
        tick();
        reset = 1'b0;
        tick();
        io = in_log.size(); ro = rsp_log.size();
        core_xbase = 32'h0000_A000;
        asked[2]++;
        wait_jobs("rd_fresh", 16'd1);
        repeat (3) tick();
        check_job("rd_fresh", 2, 32'h0000_A000, io, ro);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: sim time limit reached");
        $fatal(1);
    end

endmodule
